// File: rtl/minivan_pkg.sv
// rtl/minivan_pkg.sv - shared register-bank wire types and PWM counter constants
package minivan_pkg;

   // PWM duty wire bundle driven by the register bank
   typedef struct packed {
      logic [7:0] pwm_red;
      logic [7:0] pwm_green;
      logic [7:0] pwm_blue;
   } rb_pwm_cfg_wire_t;

   localparam int                    PWM_CNT_W   = 8;
   localparam logic [PWM_CNT_W-1:0]  PWM_CNT_MAX = 8'd254;

endpackage

// File: rtl/rgb_pwm_gamma.sv
// rtl/rgb_pwm_gamma.sv - duty gamma curve (d*d + 2*d) >> 8, built only with RGB_PWM_GAMMA_EN
`ifdef RGB_PWM_GAMMA_EN
module rgb_pwm_gamma (
   input  logic [7:0] duty,
   output logic [7:0] duty_gamma
);

   logic [15:0] curve;

   // The +2d term lifts the top code so that 255 maps exactly to 255
   always_comb begin
      curve      = 16'(duty) * 16'(duty) + {7'd0, duty, 1'b0};
      duty_gamma = 8'(curve >> 8);
   end

endmodule
`endif

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - three-channel period-synchronous PWM LED driver (option: RGB_PWM_GAMMA_EN)
module rgb_pwm_driver
   import minivan_pkg::*;
#(
   parameter int PRESCALE       = 4,
   parameter bit LED_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  rb_pwm_cfg_wire_t pwm_cfg,
   input  logic             enable,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b,
   output logic             period_start
);

   localparam int              PRE_W    = $clog2(PRESCALE + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]           state;
   logic [PRE_W-1:0]     pre_cnt;
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic [7:0]           shadow_r, shadow_g, shadow_b;
   logic [7:0]           duty_r, duty_g, duty_b;
   logic                 tick, wrap, start;

`ifdef RGB_PWM_GAMMA_EN
   rgb_pwm_gamma u_gamma_r (.duty(pwm_cfg.pwm_red),   .duty_gamma(duty_r));
   rgb_pwm_gamma u_gamma_g (.duty(pwm_cfg.pwm_green), .duty_gamma(duty_g));
   rgb_pwm_gamma u_gamma_b (.duty(pwm_cfg.pwm_blue),  .duty_gamma(duty_b));
`else
   assign duty_r = pwm_cfg.pwm_red;
   assign duty_g = pwm_cfg.pwm_green;
   assign duty_b = pwm_cfg.pwm_blue;
`endif

   // Period timing: prescaler tick, end-of-period wrap, first clock after enable rises
   always_comb begin
      tick  = enable && (pre_cnt == PRE_LAST);
      wrap  = tick && (pwm_cnt == PWM_CNT_MAX);
      start = enable && (state == ST_IDLE);
   end

   // Counters, shadow duties and registered pad drive; disable overrides a coincident wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         shadow_r     <= '0;
         shadow_g     <= '0;
         shadow_b     <= '0;
         period_start <= 1'b0;
         led_r        <= LED_ACTIVE_LOW;
         led_g        <= LED_ACTIVE_LOW;
         led_b        <= LED_ACTIVE_LOW;
      end else if (!enable) begin
         state        <= ST_IDLE;
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         shadow_r     <= duty_r;
         shadow_g     <= duty_g;
         shadow_b     <= duty_b;
         period_start <= 1'b0;
         led_r        <= LED_ACTIVE_LOW;
         led_g        <= LED_ACTIVE_LOW;
         led_b        <= LED_ACTIVE_LOW;
      end else begin
         state        <= ST_RUN;
         period_start <= wrap || start;
         if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= wrap ? '0 : pwm_cnt + PWM_CNT_W'(1);
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
         if (wrap || start) begin
            shadow_r <= duty_r;
            shadow_g <= duty_g;
            shadow_b <= duty_b;
         end
         led_r <= (pwm_cnt < shadow_r) ^ LED_ACTIVE_LOW;
         led_g <= (pwm_cnt < shadow_g) ^ LED_ACTIVE_LOW;
         led_b <= (pwm_cnt < shadow_b) ^ LED_ACTIVE_LOW;
      end
   end

endmodule
